dac_play_buf: RTL and testbench

Per-DAC playout buffer that sits directly downstream of `beam_mux`, one instance on each `dacN_t_data`/`dacN_t_valid` output. The mux pushes samples in bursts with no backpressure; this block absorbs them in a FIFO, primes to a fill threshold, then plays samples to the DAC at a fixed strobe rate. It flags overflow (dropped input) and underrun (starved output) with sticky status bits.

---
 rtl/dac_play_buf.sv | 159 +++++++++++++++
 tb/tb_dac_play_buf.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_play_buf.sv
// Playout buffer between beam_mux and one DAC: absorbs sample bursts,
// primes to a fill threshold, then plays at a fixed strobe rate.
module dac_play_buf #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int START_LVL = 4,
    parameter int RATE_DIV  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr_flags,
    input  logic [DATA_W-1:0]        in_t_data,
    input  logic                     in_t_valid,
    output logic [DATA_W-1:0]        dac_data,
    output logic                     dac_stb,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     playing,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_LVL = LW'(START_LVL);
    localparam logic [CW-1:0] CNT_MAX   = CW'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                stb_q, stb_d;
    logic                play_q, play_d;
    logic                ovf_q, ovf_d;
    logic                udr_q, udr_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic full;
    logic empty;
    logic wr_en;
    logic drop;
    logic tick;
    logic rd_en;
    logic starve;

    // Full/empty come from the registered level, so a same-cycle
    // read never rescues a write and a same-cycle write never
    // rescues a starved tick.
    always_comb begin
        full   = (level_q == FULL_LVL);
        empty  = (level_q == '0);
        wr_en  = in_t_valid && !full;
        drop   = in_t_valid && full;
        tick   = (state_q == S_PLAY) && en && (cnt_q == CNT_MAX);
        rd_en  = tick && !empty;
        starve = tick && empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);

        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_PRIME;
                end
                S_PRIME: begin
                    if (level_q >= PRIME_LVL) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end
                end
                S_PLAY: begin
                    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
                    if (starve) begin
                        state_d = S_PRIME;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (rd_en) begin
            data_d = mem_q[rd_ptr_q];
        end else if (starve) begin
            data_d = '0;
        end else begin
            data_d = data_q;
        end

        stb_d  = tick;
        play_d = (state_d == S_PLAY);
        ovf_d  = drop | (ovf_q & ~clr_flags);
        udr_d  = starve | (udr_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            stb_q    <= 1'b0;
            play_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            stb_q    <= stb_d;
            play_q   <= play_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_t_data;
        end
    end

    assign dac_data = data_q;
    assign dac_stb  = stb_q;
    assign level    = level_q;
    assign playing  = play_q;
    assign overflow = ovf_q;
    assign underrun = udr_q;

endmodule

// File: tb/tb_dac_play_buf.sv
// Bench for dac_play_buf: queue-based reference model checked every
// cycle, directed scenarios, then randomized traffic.
module tb_dac_play_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int START = 4;
    localparam int RATE  = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic          vin = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dac_data;
    logic          dac_stb;
    logic [LW-1:0] level;
    logic          playing;
    logic          overflow;
    logic          underrun;

    dac_play_buf #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .START_LVL (START),
        .RATE_DIV  (RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr_flags  (clr),
        .in_t_data  (din),
        .in_t_valid (vin),
        .dac_data   (dac_data),
        .dac_stb    (dac_stb),
        .level      (level),
        .playing    (playing),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];
    int            m_mode = 0;
    int            m_ph   = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_stb  = 1'b0;
    bit            m_ovf  = 1'b0;
    bit            m_udr  = 1'b0;

    int            cyc   = 0;
    int            lvl4  = -1;
    int            prise = -1;
    logic [DW-1:0] outq[$];
    int            stb_t[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // mode: 0 idle, 1 waiting for fill, 2 playing
    task automatic model_step();
        int n;
        bit tick;
        bit drop;
        bit starve;
        if (!rst) begin
            m_q.delete();
            m_mode = 0;
            m_ph   = 0;
            m_data = '0;
            m_stb  = 1'b0;
            m_ovf  = 1'b0;
            m_udr  = 1'b0;
            return;
        end
        n      = m_q.size();
        tick   = (m_mode == 2) && en && (m_ph == RATE - 1);
        drop   = vin && (n == DEPTH);
        starve = tick && (n == 0);
        m_stb  = tick;
        if (tick) begin
            if (n > 0) m_data = m_q.pop_front();
            else       m_data = '0;
        end
        if (vin && n < DEPTH) m_q.push_back(din);
        m_ovf = drop || (m_ovf && !clr);
        m_udr = starve || (m_udr && !clr);
        if (!en) begin
            m_mode = 0;
            m_ph   = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (n >= START) begin
                m_mode = 2;
                m_ph   = 0;
            end
        end else begin
            m_ph = (m_ph + 1) % RATE;
            if (starve) m_mode = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("stb", 64'(dac_stb), 64'(m_stb));
        chk("data", 64'(dac_data), 64'(m_data));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("playing", 64'(playing), 64'(m_mode == 2));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underrun", 64'(underrun), 64'(m_udr));
        if (dac_stb) begin
            outq.push_back(dac_data);
            stb_t.push_back(cyc);
        end
        if (lvl4 < 0 && level == LW'(START)) lvl4 = cyc;
        if (prise < 0 && playing) prise = cyc;
    endtask

    task automatic run_until(input int n, input int bound);
        int k = 0;
        while (outq.size() < n && k < bound) begin
            cycle();
            k++;
        end
        chk("strobe_timeout", 64'(outq.size() >= n), 64'(1));
    endtask

    task automatic write_seq(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            din = DW'(base + i);
            vin = 1'b1;
            cycle();
        end
        vin = 1'b0;
    endtask

    initial begin
        int k;
        int dens;

        // reset held with traffic present
        rst = 1'b0;
        vin = 1'b1;
        din = 32'hdead_beef;
        repeat (3) begin
            cycle();
            chk("rst_level", 64'(level), 64'(0));
            chk("rst_stb", 64'(dac_stb), 64'(0));
        end
        vin = 1'b0;
        rst = 1'b1;
        en  = 1'b1;

        // prime and play
        outq.delete();
        stb_t.delete();
        lvl4  = -1;
        prise = -1;
        write_seq(0, 10);
        run_until(10, 100);
        en = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++)
            chk("play_seq", 64'(outq[i]), 64'(i));
        for (int i = 1; i < 10; i++)
            chk("play_gap", 64'(stb_t[i] - stb_t[i-1]), 64'(RATE));
        chk("play_rise", 64'(prise - lvl4), 64'(1));

        // overflow while idle
        outq.delete();
        write_seq(100, 20);
        cycle();
        chk("ovf_level", 64'(level), 64'(DEPTH));
        chk("ovf_flag", 64'(overflow), 64'(1));
        en = 1'b1;
        run_until(16, 200);
        en = 1'b0;
        cycle();
        chk("ovf_count", 64'(outq.size()), 64'(16));
        for (int i = 0; i < 16; i++)
            chk("ovf_seq", 64'(outq[i]), 64'(100 + i));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'(0));

        // underrun and resume
        outq.delete();
        en = 1'b1;
        write_seq(200, 4);
        run_until(5, 100);
        chk("udr_zero", 64'(outq[4]), 64'(0));
        chk("udr_flag", 64'(underrun), 64'(1));
        cycle();
        chk("udr_stop", 64'(playing), 64'(0));
        write_seq(204, 4);
        run_until(9, 100);
        en = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("udr_seq_a", 64'(outq[i]), 64'(200 + i));
            chk("udr_seq_b", 64'(outq[5+i]), 64'(204 + i));
        end

        // clear colliding with a dropped write
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        write_seq(300, 16);
        vin = 1'b1;
        clr = 1'b1;
        cycle();
        chk("clr_collide", 64'(overflow), 64'(1));
        vin = 1'b0;
        cycle();
        clr = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'(0));
        chk("clr_udr", 64'(underrun), 64'(0));

        // reset while playing
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        write_seq(400, 7);
        en = 1'b1;
        k = 0;
        while (!playing && k < 10) begin
            cycle();
            k++;
        end
        chk("mid_playing", 64'(playing), 64'(1));
        chk("mid_level", 64'(level), 64'(7));
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_play", 64'(playing), 64'(0));
        outq.delete();
        repeat (20) cycle();
        chk("mid_no_stb", 64'(outq.size()), 64'(0));
        write_seq(500, 4);
        run_until(4, 50);
        en = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++)
            chk("mid_seq", 64'(outq[i]), 64'(500 + i));

        // randomized traffic with varying burst density
        dens = 25;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(5, 60);
            rst = ($urandom_range(0, 199) != 0);
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 29) == 0);
            vin = ($urandom_range(0, 99) < dens);
            din = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
